// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling UART receiver, LSB-first data, optional parity, stop check.
// Define UART_RX_MAJORITY_EN to decide every bit by 2-of-3 majority around mid-bit.
module uart_rx_deserializer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA,
    output logic             data_valid,
    output logic             parity_error,
    output logic             stop_error,
    output logic             Busy
);
    localparam int EW = $clog2(PRESCALE);
    localparam int BW = $clog2(WIDTH + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [EW-1:0] DECIDE = EW'(PRESCALE / 2);
`else
    localparam logic [EW-1:0] DECIDE = EW'(PRESCALE / 2 - 1);
`endif
    localparam logic [EW-1:0] LAST     = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic             rx_meta, rx_s, rx_prev;
    logic [EW-1:0]    edge_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             par_en_q, par_typ_q, par_err;
    logic             smp, wrap, bit_val;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;
    // capture the two samples that precede the decision point
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maj_q <= 2'b11;
        end else begin
            if (edge_cnt == EW'(PRESCALE / 2 - 2)) maj_q[0] <= rx_s;
            if (edge_cnt == EW'(PRESCALE / 2 - 1)) maj_q[1] <= rx_s;
        end
    end
    assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign Busy = state != IDLE;

    // two-flop synchroniser plus a delayed copy so IDLE only reacts to a real falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rx_meta, rx_s, rx_prev} <= 3'b111;
        else      {rx_meta, rx_s, rx_prev} <= {RX_IN, rx_meta, rx_s};
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state logic; STOP leaves at the decision point so the next start edge is caught
    always_comb begin
        smp       = (state != IDLE) && (edge_cnt == DECIDE);
        wrap      = edge_cnt == LAST;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (rx_prev && !rx_s) ? START : IDLE;
            START:   state_nxt = (smp && bit_val) ? IDLE : wrap ? DATA : START;
            DATA:    state_nxt = !(wrap && bit_cnt == LAST_BIT) ? DATA : par_en_q ? PARITY : STOP;
            PARITY:  state_nxt = wrap ? STOP : PARITY;
            STOP:    state_nxt = smp ? IDLE : STOP;
            default: state_nxt = IDLE;
        endcase
    end

    // counters, shift register, parity check and the single result pulse after the stop sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_err      <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            edge_cnt     <= (state == IDLE || wrap) ? '0 : edge_cnt + 1'b1;
            if (state == IDLE) begin
                bit_cnt   <= '0;
                par_err   <= 1'b0;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
            if (state == DATA && smp) shift_reg <= {bit_val, shift_reg[WIDTH-1:1]};
            if (state == DATA && wrap) bit_cnt <= bit_cnt + 1'b1;
            if (state == PARITY && smp) par_err <= bit_val != (^shift_reg ^ par_typ_q);
            if (state == STOP && smp) begin
                stop_error   <= !bit_val;
                parity_error <= bit_val && par_err;
                data_valid   <= bit_val && !par_err;
                if (bit_val && !par_err) P_DATA <= shift_reg;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames with a scoreboard of expected result pulses.
module tb_uart_rx_deserializer;
    localparam int W  = 8;
    localparam int PS = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int ADJ = 1;
`else
    localparam int ADJ = 0;
`endif
    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_PAR   = 3'b010;
    localparam logic [2:0] K_STOP  = 3'b001;

    typedef struct {
        logic [2:0]   kind;
        logic [W-1:0] data;
        int           at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx_in = 1'b1;
    logic         par_en = 1'b0;
    logic         par_typ = 1'b0;
    logic [W-1:0] p_data;
    logic         data_valid, parity_error, stop_error, busy;
    logic [W-1:0] model_q = '0;
    exp_t         sb[$];
    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;
    logic         seen;

    uart_rx_deserializer #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk(clk),
        .rst(rst),
        .RX_IN(rx_in),
        .PAR_EN(par_en),
        .PAR_TYP(par_typ),
        .P_DATA(p_data),
        .data_valid(data_valid),
        .parity_error(parity_error),
        .stop_error(stop_error),
        .Busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic bit_out(input logic b);
        rx_in = b;
        repeat (PS) @(negedge clk);
    endtask

    task automatic frame(input logic [W-1:0] d, input logic pbit, input logic sbit);
        bit_out(1'b0);
        for (int i = 0; i < W; i++) bit_out(d[i]);
        if (par_en) bit_out(pbit);
        bit_out(sbit);
    endtask

    function automatic logic par_of(input logic [W-1:0] d);
        return ^d ^ par_typ;
    endfunction

    task automatic expect_pulse(input logic [2:0] k, input logic [W-1:0] d, input int at);
        if (k == K_VALID) model_q = d;
        sb.push_back('{k, model_q, at});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && (data_valid || parity_error || stop_error)) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pulse_kind", {data_valid, parity_error, stop_error}, e.kind);
                chk("p_data", p_data, e.data);
                if (e.at != 0) chk("latency", cyc, e.at);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_p_data", p_data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_perr", parity_error, 0);
        chk("rst_serr", stop_error, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        par_en  = 1'b1;
        par_typ = 1'b0;
        expect_pulse(K_VALID, 8'hA5, cyc + 7 + (2 + W) * PS + ADJ);
        frame(8'hA5, par_of(8'hA5), 1'b1);
        bit_out(1'b1);
        bit_out(1'b1);

        expect_pulse(K_PAR, 8'h00, 0);
        frame(8'hA5, ~par_of(8'hA5), 1'b1);
        bit_out(1'b1);
        bit_out(1'b1);

        par_en = 1'b0;
        expect_pulse(K_STOP, 8'h00, 0);
        frame(8'h3C, 1'b0, 1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        expect_pulse(K_VALID, 8'h3C, 0);
        frame(8'h3C, 1'b0, 1'b1);
        bit_out(1'b1);

        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("glitch_busy_rise", seen, 1);
        for (int i = 0; i < PS && busy; i++) @(negedge clk);
        chk("glitch_busy_fall", busy, 0);
        bit_out(1'b1);

        par_en  = 1'b1;
        par_typ = 1'b1;
        expect_pulse(K_VALID, 8'h00, 0);
        frame(8'h00, par_of(8'h00), 1'b1);
        expect_pulse(K_VALID, 8'hFF, 0);
        frame(8'hFF, par_of(8'hFF), 1'b1);
        bit_out(1'b1);
        bit_out(1'b1);

        par_en = 1'b0;
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_p_data", p_data, 0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_perr", parity_error, 0);
        chk("midrst_serr", stop_error, 0);
        chk("midrst_busy", busy, 0);
        model_q = '0;
        @(negedge clk);
        rx_in = 1'b1;
        rst   = 1'b1;
        bit_out(1'b1);
        bit_out(1'b1);
        expect_pulse(K_VALID, 8'h5A, 0);
        frame(8'h5A, 1'b0, 1'b1);
        bit_out(1'b1);
        bit_out(1'b1);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
